// File: rtl/uart_gonderim_denetleyicisi.sv
// Purpose    : pops bytes from the UART TX FIFO and hands each one to the bit engine, one frame at a time.
// Latency    : pop in cycle N, transmitter start pulse in N+1; next pop no earlier than 1 + idle-gap cycles after the frame ends.
// Backpressure: a pop happens only when the transmitter reports idle; while it is busy the FIFO is left untouched.
//
// Ports
//   clk_i, rstn_i            : clock, asynchronous active-low reset
//   tx_en_i                  : transmit enable, sampled only while idle
//   baud_div_i               : baud divisor, latched at pop (zero blocks transmission)
//   ara_bosluk_i             : idle clocks inserted after each frame, sampled when the frame ends
//   sayac_temizle_i          : synchronous clear of the sent-byte counter (wins over an increment)
//   fifo_veri_i, fifo_bos_i  : first-word-fall-through FIFO head and empty flag
//   fifo_oku_o               : pop strobe, the FIFO advances on the edge where it is high
//   verici_basla_o           : one-cycle start pulse to the transmitter
//   verici_veri_gecerli_o    : transmitter data valid, same as the start pulse
//   verici_veri_o            : byte being transmitted, held until the next pop
//   verici_baud_div_o        : divisor latched at pop, held for the whole frame
//   verici_hazir_i           : transmitter idle; drops after an accepted start, rises when the stop bit ends
//   mesgul_o                 : high whenever the sequencer is not idle
//   gonderilen_sayac_o       : number of completed frames, wraps at full scale

module uart_gonderim_denetleyicisi #(
   parameter int VERI_W  = 8,
   parameter int BAUD_W  = 16,
   parameter int ARA_W   = 8,
   parameter int SAYAC_W = 16
) (
   input  logic               clk_i,
   input  logic               rstn_i,
   input  logic               tx_en_i,
   input  logic [BAUD_W-1:0]  baud_div_i,
   input  logic [ARA_W-1:0]   ara_bosluk_i,
   input  logic               sayac_temizle_i,
   input  logic [VERI_W-1:0]  fifo_veri_i,
   input  logic               fifo_bos_i,
   output logic               fifo_oku_o,
   output logic               verici_basla_o,
   output logic               verici_veri_gecerli_o,
   output logic [VERI_W-1:0]  verici_veri_o,
   output logic [BAUD_W-1:0]  verici_baud_div_o,
   input  logic               verici_hazir_i,
   output logic               mesgul_o,
   output logic [SAYAC_W-1:0] gonderilen_sayac_o
);

   typedef enum logic [2:0] {
      BOSTA       = 3'd0,
      BASLAT      = 3'd1,
      DUSUS_BEKLE = 3'd2,
      BITIS_BEKLE = 3'd3,
      ARA         = 3'd4
   } durum_t;

   durum_t              durum_q;
   durum_t              durum_d;
   logic [ARA_W-1:0]    ara_q;
   logic [ARA_W-1:0]    ara_d;
   logic [VERI_W-1:0]   veri_q;
   logic [BAUD_W-1:0]   baud_q;
   logic [SAYAC_W-1:0]  sayac_q;
   logic                basla_kosulu;
   logic                sayac_artir;
   logic                oku;

   // Everything needed to launch a frame must be present in the same cycle:
   // enable, data, a usable divisor and an idle transmitter.
   assign basla_kosulu = tx_en_i & ~fifo_bos_i & (baud_div_i != '0) & verici_hazir_i;

   // Next-state and Mealy pop decode.
   always_comb begin
      durum_d     = durum_q;
      ara_d       = ara_q;
      oku         = 1'b0;
      sayac_artir = 1'b0;
      unique case (durum_q)
         BOSTA: begin
            if (basla_kosulu) begin
               oku     = 1'b1;
               durum_d = BASLAT;
            end
         end
         BASLAT: begin
            durum_d = DUSUS_BEKLE;
         end
         DUSUS_BEKLE: begin
            // Wait for the transmitter to acknowledge the start by going busy,
            // otherwise a still-high ready would end the frame immediately.
            if (!verici_hazir_i) begin
               durum_d = BITIS_BEKLE;
            end
         end
         BITIS_BEKLE: begin
            if (verici_hazir_i) begin
               sayac_artir = 1'b1;
               if (ara_bosluk_i != '0) begin
                  ara_d   = ara_bosluk_i;
                  durum_d = ARA;
               end else begin
                  durum_d = BOSTA;
               end
            end
         end
         ARA: begin
            // Loaded with G on entry and left when it reads 1: exactly G cycles here.
            ara_d = ara_q - ARA_W'(1);
            if (ara_q == ARA_W'(1)) begin
               durum_d = BOSTA;
            end
         end
         default: begin
            durum_d = BOSTA;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         durum_q <= BOSTA;
         ara_q   <= '0;
         veri_q  <= '0;
         baud_q  <= '0;
         sayac_q <= '0;
      end else begin
         durum_q <= durum_d;
         ara_q   <= ara_d;
         if (oku) begin
            veri_q <= fifo_veri_i;
            baud_q <= baud_div_i;
         end
         if (sayac_temizle_i) begin
            sayac_q <= '0;
         end else if (sayac_artir) begin
            sayac_q <= sayac_q + SAYAC_W'(1);
         end
      end
   end

   // The pop is combinational from the idle state, so it is also qualified by
   // reset: a held reset must never advance the FIFO.
   assign fifo_oku_o            = oku & rstn_i;
   assign verici_basla_o        = (durum_q == BASLAT);
   assign verici_veri_gecerli_o = verici_basla_o;
   assign verici_veri_o         = veri_q;
   assign verici_baud_div_o     = baud_q;
   assign mesgul_o              = (durum_q != BOSTA);
   assign gonderilen_sayac_o    = sayac_q;

   a_pop_not_empty : assert property (@(posedge clk_i) disable iff (!rstn_i)
      fifo_oku_o |-> !fifo_bos_i);

   a_start_one_cycle : assert property (@(posedge clk_i) disable iff (!rstn_i)
      verici_basla_o |=> !verici_basla_o);

endmodule

// File: tb/tb_uart_gonderim_denetleyicisi.sv
// Purpose    : self-checking bench for the UART TX sequencer with a FIFO model, a transmitter model and a timeline reference model.
// Latency    : one cycle() call per clock; inputs set at posedge+1, outputs sampled at posedge+2.
// Backpressure: the transmitter model holds ready low for tx_len cycles after each accepted start.

module tb_uart_gonderim_denetleyicisi;

   logic        clk = 1'b0;
   logic        rstn_i;
   logic        tx_en_i;
   logic [15:0] baud_div_i;
   logic [7:0]  ara_bosluk_i;
   logic        sayac_temizle_i;
   logic [7:0]  fifo_veri_i;
   logic        fifo_bos_i;
   logic        fifo_oku_o;
   logic        verici_basla_o;
   logic        verici_veri_gecerli_o;
   logic [7:0]  verici_veri_o;
   logic [15:0] verici_baud_div_o;
   logic        verici_hazir_i;
   logic        mesgul_o;
   logic [15:0] gonderilen_sayac_o;

   // Second instance with a 3-bit counter sharing every input: exposes the wrap quickly.
   logic        k_oku, k_basla, k_gecerli, k_mesgul;
   logic [7:0]  k_veri;
   logic [15:0] k_baud;
   logic [2:0]  k_sayac;

   initial forever #5 clk = ~clk;

   uart_gonderim_denetleyicisi dut (
      .clk_i(clk), .rstn_i(rstn_i), .tx_en_i(tx_en_i), .baud_div_i(baud_div_i),
      .ara_bosluk_i(ara_bosluk_i), .sayac_temizle_i(sayac_temizle_i),
      .fifo_veri_i(fifo_veri_i), .fifo_bos_i(fifo_bos_i), .fifo_oku_o(fifo_oku_o),
      .verici_basla_o(verici_basla_o), .verici_veri_gecerli_o(verici_veri_gecerli_o),
      .verici_veri_o(verici_veri_o), .verici_baud_div_o(verici_baud_div_o),
      .verici_hazir_i(verici_hazir_i), .mesgul_o(mesgul_o),
      .gonderilen_sayac_o(gonderilen_sayac_o)
   );

   uart_gonderim_denetleyicisi #(.SAYAC_W(3)) dut_k (
      .clk_i(clk), .rstn_i(rstn_i), .tx_en_i(tx_en_i), .baud_div_i(baud_div_i),
      .ara_bosluk_i(ara_bosluk_i), .sayac_temizle_i(sayac_temizle_i),
      .fifo_veri_i(fifo_veri_i), .fifo_bos_i(fifo_bos_i), .fifo_oku_o(k_oku),
      .verici_basla_o(k_basla), .verici_veri_gecerli_o(k_gecerli),
      .verici_veri_o(k_veri), .verici_baud_div_o(k_baud),
      .verici_hazir_i(verici_hazir_i), .mesgul_o(k_mesgul),
      .gonderilen_sayac_o(k_sayac)
   );

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   // FIFO and transmitter models
   logic [7:0] fifo_q[$];
   int         tx_len = 3;
   int         tx_rem = 0;
   bit         tx_ignore = 0;

   // Reference model: frame timeline and register contents
   bit          m_in_frame = 0;
   bit          m_seen_low = 0;
   bit          m_start_now = 0;
   int          m_ready = 0;
   logic [15:0] m_cnt = '0;
   logic [7:0]  m_data = '0;
   logic [15:0] m_baud = '0;
   bit          ev_done = 0;

   bit          obs_pop, obs_start, obs_busy;
   logic [7:0]  obs_data;
   logic [15:0] obs_baud;

   typedef struct {
      logic [7:0]  dat;
      logic [15:0] baud;
      logic [7:0]  ara;
      int          tlen;
      logic [7:0]  exp_dat;
      logic [15:0] exp_baud;
      int          exp_gap;
      int          exp_lat;
   } vec_t;

   vec_t vt[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: present FIFO head, compare against the model, advance the model,
   // then clock and update the FIFO and transmitter models.
   task automatic cycle();
      bit exp_pop;
      bit inc;
      fifo_bos_i  = (fifo_q.size() == 0);
      fifo_veri_i = fifo_bos_i ? 8'h00 : fifo_q[0];
      #1;
      exp_pop = !m_in_frame && (cyc >= m_ready) && tx_en_i && !fifo_bos_i &&
                (baud_div_i != 16'd0) && verici_hazir_i;
      obs_pop   = fifo_oku_o;
      obs_start = verici_basla_o;
      obs_busy  = mesgul_o;
      obs_data  = verici_veri_o;
      obs_baud  = verici_baud_div_o;
      chk("pop", fifo_oku_o, exp_pop);
      chk("start", verici_basla_o, m_start_now);
      chk("valid", verici_veri_gecerli_o, m_start_now);
      chk("data", verici_veri_o, m_data);
      chk("baud", verici_baud_div_o, m_baud);
      chk("busy", mesgul_o, m_in_frame || (cyc < m_ready));
      chk("count", gonderilen_sayac_o, m_cnt);
      chk("count_w3", k_sayac, m_cnt % 8);

      inc = 0;
      ev_done = 0;
      if (exp_pop) begin
         m_in_frame = 1;
         m_seen_low = 0;
         m_data = fifo_q[0];
         m_baud = baud_div_i;
      end else if (m_in_frame && !m_start_now) begin
         if (!m_seen_low) begin
            if (!verici_hazir_i) m_seen_low = 1;
         end else if (verici_hazir_i) begin
            m_in_frame = 0;
            m_ready = cyc + 1 + int'(ara_bosluk_i);
            inc = 1;
            ev_done = 1;
         end
      end
      if (sayac_temizle_i) m_cnt = '0;
      else if (inc) m_cnt = m_cnt + 16'd1;
      m_start_now = exp_pop;

      @(posedge clk);
      #1;
      cyc++;
      if (exp_pop) void'(fifo_q.pop_front());
      if (obs_start && verici_hazir_i && !tx_ignore) begin
         verici_hazir_i = 0;
         tx_rem = tx_len;
      end else if (!verici_hazir_i) begin
         if (tx_rem > 1) tx_rem--;
         else verici_hazir_i = 1;
      end
   endtask

   task automatic do_reset_check(input string tag);
      rstn_i = 0;
      #2;
      chk({tag, "_pop"}, fifo_oku_o, 0);
      chk({tag, "_start"}, verici_basla_o, 0);
      chk({tag, "_valid"}, verici_veri_gecerli_o, 0);
      chk({tag, "_data"}, verici_veri_o, 0);
      chk({tag, "_baud"}, verici_baud_div_o, 0);
      chk({tag, "_busy"}, mesgul_o, 0);
      chk({tag, "_count"}, gonderilen_sayac_o, 0);
      chk({tag, "_w3_busy"}, k_mesgul, 0);
      chk({tag, "_w3_count"}, k_sayac, 0);
      m_in_frame = 0; m_seen_low = 0; m_start_now = 0;
      m_cnt = '0; m_data = '0; m_baud = '0;
      @(posedge clk);
      #1;
      cyc++;
      m_ready = cyc;
      tx_ignore = 0;
      verici_hazir_i = 1;
      rstn_i = 1;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int pop_c = -1, start_c = -1, done_c = -1, gap = 0;
      logic [7:0]  sd = '0;
      logic [15:0] sb = '0;
      fifo_q.push_back(v.dat);
      baud_div_i = v.baud; ara_bosluk_i = v.ara; tx_len = v.tlen; tx_en_i = 1;
      for (int k = 0; k < 600; k++) begin
         cycle();
         if (obs_pop && pop_c < 0) pop_c = k;
         if (obs_start && start_c < 0) begin start_c = k; sd = obs_data; sb = obs_baud; end
         if (done_c >= 0) begin
            if (obs_busy) gap++;
            else break;
         end
         if (ev_done) done_c = k;
      end
      chk($sformatf("v%0d_done", idx), done_c >= 0, 1);
      chk($sformatf("v%0d_lat", idx), start_c - pop_c, v.exp_lat);
      chk($sformatf("v%0d_dat", idx), sd, v.exp_dat);
      chk($sformatf("v%0d_baud", idx), sb, v.exp_baud);
      chk($sformatf("v%0d_gap", idx), gap, v.exp_gap);
      chk($sformatf("v%0d_idle", idx), obs_busy, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{8'hA5, 16'd16,     8'd0,   4, 8'hA5, 16'd16,     0,   1};
      vt[1] = '{8'h01, 16'd16,     8'd5,   3, 8'h01, 16'd16,     5,   1};
      vt[2] = '{8'h02, 16'd16,     8'd5,   3, 8'h02, 16'd16,     5,   1};
      vt[3] = '{8'h03, 16'd16,     8'd5,   3, 8'h03, 16'd16,     5,   1};
      vt[4] = '{8'hFF, 16'd1,      8'd1,   1, 8'hFF, 16'd1,      1,   1};
      vt[5] = '{8'h5A, 16'hFFFF,   8'd255, 2, 8'h5A, 16'hFFFF,   255, 1};

      rstn_i = 0; tx_en_i = 0; baud_div_i = '0; ara_bosluk_i = '0;
      sayac_temizle_i = 0; fifo_veri_i = '0; fifo_bos_i = 1; verici_hazir_i = 1;
      do_reset_check("reset");

      // Table-driven single frames
      for (int i = 0; i < 6; i++) begin
         run_vec(vt[i], i);
         if (i == 0) chk("single_count", gonderilen_sayac_o, 1);
      end

      // Burst of three with a 5-cycle gap
      begin
         int dc[$];
         int pc[$];
         logic [7:0]  sq[$];
         logic [15:0] c0;
         c0 = gonderilen_sayac_o;
         fifo_q.push_back(8'h01); fifo_q.push_back(8'h02); fifo_q.push_back(8'h03);
         ara_bosluk_i = 8'd5; baud_div_i = 16'd16; tx_len = 3; tx_en_i = 1;
         for (int k = 0; k < 400; k++) begin
            cycle();
            if (obs_pop) pc.push_back(k);
            if (obs_start) sq.push_back(obs_data);
            if (ev_done) dc.push_back(k);
            if (dc.size() == 3 && !obs_busy) break;
         end
         chk("burst_frames", dc.size(), 3);
         chk("burst_pops", pc.size(), 3);
         if (sq.size() == 3) begin
            for (int i = 0; i < 3; i++) chk($sformatf("burst_dat%0d", i), sq[i], i + 1);
         end
         if (pc.size() == 3 && dc.size() == 3) begin
            for (int i = 0; i < 2; i++) chk($sformatf("burst_gap%0d", i), pc[i+1] - dc[i], 6);
         end
         chk("burst_count", gonderilen_sayac_o - c0, 3);
      end

      // Blocking: zero divisor, then disabled
      begin
         int np = 0, ns = 0;
         fifo_q.push_back(8'h77);
         baud_div_i = 16'd0; tx_en_i = 1; ara_bosluk_i = 8'd0;
         for (int k = 0; k < 1000; k++) begin
            cycle();
            if (obs_pop) np++;
            if (obs_start) ns++;
         end
         chk("block_baud0_pops", np, 0);
         chk("block_baud0_starts", ns, 0);
         np = 0; ns = 0;
         baud_div_i = 16'd16; tx_en_i = 0;
         for (int k = 0; k < 1000; k++) begin
            cycle();
            if (obs_pop) np++;
            if (obs_start) ns++;
         end
         chk("block_dis_pops", np, 0);
         chk("block_dis_starts", ns, 0);
         fifo_q.delete();
      end

      // Enable dropped and divisor changed while waiting for the frame end
      begin
         bit changed = 0, doneflag = 0;
         int npa = 0;
         logic [15:0] sb = '0;
         fifo_q.push_back(8'h44); fifo_q.push_back(8'h45);
         baud_div_i = 16'd16; tx_en_i = 1; ara_bosluk_i = 8'd2; tx_len = 8;
         for (int k = 0; k < 200; k++) begin
            if (!changed && m_in_frame && m_seen_low) begin
               tx_en_i = 0; baud_div_i = 16'd99; changed = 1;
            end
            cycle();
            if (obs_start) sb = obs_baud;
            if (changed && obs_pop) npa++;
            if (ev_done) doneflag = 1;
         end
         chk("mid_changed", changed, 1);
         chk("mid_done", doneflag, 1);
         chk("mid_start_baud", sb, 16);
         chk("mid_held_baud", verici_baud_div_o, 16);
         chk("mid_no_pop", npa, 0);
         chk("mid_fifo_left", fifo_q.size(), 1);
         fifo_q.delete();
      end

      // Clear coincident with the frame end
      begin
         bit hit = 0, clr;
         fifo_q.push_back(8'h66);
         tx_en_i = 1; baud_div_i = 16'd16; ara_bosluk_i = 8'd0; tx_len = 3;
         for (int k = 0; k < 100; k++) begin
            clr = m_in_frame && m_seen_low && verici_hazir_i;
            sayac_temizle_i = clr;
            cycle();
            sayac_temizle_i = 0;
            if (clr && ev_done) hit = 1;
            if (hit && !obs_busy) break;
         end
         chk("clr_coincident", hit, 1);
         chk("clr_count", gonderilen_sayac_o, 0);
      end

      // Wrap of the narrow counter: 7 (all ones) then one more frame gives 0
      begin
         int nd = 0;
         for (int i = 0; i < 8; i++) fifo_q.push_back(8'(8'h10 + i));
         ara_bosluk_i = 8'd0; tx_len = 1;
         for (int k = 0; k < 400 && nd < 8; k++) begin
            cycle();
            if (ev_done) begin
               nd++;
               if (nd == 7) chk("wrap_w3_full", k_sayac, 7);
               if (nd == 8) chk("wrap_w3_zero", k_sayac, 0);
            end
         end
         chk("wrap_frames", nd, 8);
         chk("wrap_main_count", gonderilen_sayac_o, 8);
      end

      // Reset while waiting for the transmitter to go busy
      begin
         bit seen = 0;
         int nd = 0;
         logic [7:0] sd = '0;
         tx_ignore = 1;
         fifo_q.push_back(8'h81); fifo_q.push_back(8'h82);
         tx_en_i = 1; baud_div_i = 16'd16; ara_bosluk_i = 8'd0; tx_len = 3;
         for (int k = 0; k < 50 && !seen; k++) begin
            cycle();
            if (obs_start) seen = 1;
         end
         chk("rst_started", seen, 1);
         repeat (3) cycle();
         do_reset_check("rst_mid");
         seen = 0;
         for (int k = 0; k < 100; k++) begin
            cycle();
            if (obs_start && !seen) begin seen = 1; sd = obs_data; end
            if (ev_done) nd++;
            if (nd > 0 && !obs_busy) break;
         end
         chk("rst_next_byte", sd, 8'h82);
         chk("rst_count", gonderilen_sayac_o, 1);
      end

      // Randomized traffic with inputs changing at arbitrary points
      for (int it = 0; it < 80; it++) begin
         int n;
         n = $urandom_range(0, 3);
         for (int j = 0; j < n; j++) if (fifo_q.size() < 32) fifo_q.push_back(8'($urandom));
         tx_en_i = ($urandom_range(0, 9) != 0);
         baud_div_i = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
         ara_bosluk_i = 8'($urandom_range(0, 6));
         tx_len = $urandom_range(1, 8);
         sayac_temizle_i = ($urandom_range(0, 15) == 0);
         repeat ($urandom_range(1, 25)) cycle();
         sayac_temizle_i = 0;
      end

      // Drain whatever is left
      tx_en_i = 1; baud_div_i = 16'd16;
      for (int k = 0; k < 3000; k++) begin
         cycle();
         if (fifo_q.size() == 0 && !obs_busy && !m_in_frame) break;
      end
      chk("drain_empty", fifo_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_gonderim_denetleyicisi.md
# uart_gonderim_denetleyicisi

Sequencer between the UART TX buffer FIFO (8-bit, 32-deep) and the `uart_verici` bit engine. When transmission is enabled it pops one byte at a time from the FIFO, latches the baud divisor, and starts the transmitter with a one-cycle pulse. It waits for the frame to finish, then inserts an optional idle gap before the next pop. It also keeps a count of bytes sent for the status register.

## Interface
- `VERI_W`, 8: byte width of FIFO data and transmitter data.
- `BAUD_W`, 16: baud divisor width.
- `ARA_W`, 8: idle-gap counter width.
- `SAYAC_W`, 16: sent-byte counter width.

Ports:
- `clk_i` in 1: single clock.
- `rstn_i` in 1: asynchronous, active-low reset.
- `tx_en_i` in 1: transmit enable (from the control register).
- `baud_div_i` in BAUD_W: baud divisor (from the control register).
- `ara_bosluk_i` in ARA_W: idle clocks inserted after each frame.
- `sayac_temizle_i` in 1: synchronous clear of the sent counter.
- `fifo_veri_i` in VERI_W: FIFO head. First-word-fall-through; valid whenever `fifo_bos_i`=0.
- `fifo_bos_i` in 1: FIFO empty.
- `fifo_oku_o` out 1: pop strobe; the FIFO advances on the clock edge where it is high.
- `verici_basla_o` out 1: transmitter start pulse.
- `verici_veri_gecerli_o` out 1: transmitter data valid; identical to `verici_basla_o`.
- `verici_veri_o` out VERI_W: byte to transmit, held until the next pop.
- `verici_baud_div_o` out BAUD_W: divisor latched at pop, held for the whole frame.
- `verici_hazir_i` in 1: transmitter idle. It drops the cycle after an accepted start and rises when the stop bit ends.
- `mesgul_o` out 1: high when state is not BOSTA.
- `gonderilen_sayac_o` out SAYAC_W: bytes completed.

## Operation
- States: BOSTA, BASLAT, DUSUS_BEKLE, BITIS_BEKLE, ARA.
- **BOSTA**
  - Start condition: `tx_en_i` & !`fifo_bos_i` & (`baud_div_i`≠0) & `verici_hazir_i`.
  - When the start condition holds:
    - `fifo_oku_o`=1 this cycle (Mealy).
    - `fifo_veri_i` is latched into the data register and `baud_div_i` into the baud register.
    - Next state is BASLAT.
  - `baud_div_i`=0 blocks the start; the block stays in BOSTA and never pops.
- **BASLAT**
  - `verici_basla_o`=`verici_veri_gecerli_o`=1 for exactly this one cycle (Moore).
  - Next state is DUSUS_BEKLE.
- **DUSUS_BEKLE**
  - Waits for `verici_hazir_i`=0, then goes to BITIS_BEKLE.
- **BITIS_BEKLE**
  - On `verici_hazir_i`=1, the counter increments.
  - Next state is ARA, with the gap counter loaded with `ara_bosluk_i`, if `ara_bosluk_i`≠0; otherwise BOSTA.
- **ARA**
  - The gap counter decrements each cycle.
  - When the value is 1, next state is BOSTA, giving exactly `ara_bosluk_i` cycles in ARA.
- **Sampling of inputs**
  - `tx_en_i` is sampled only in BOSTA. Deasserting it mid-frame lets the current frame and gap finish; no further pop follows.
  - `baud_div_i` and `ara_bosluk_i` changes mid-frame do not affect the current frame. `ara_bosluk_i` is sampled on entry to ARA.
- **Sent counter**
  - Wraps from 2^SAYAC_W−1 to 0.
  - `sayac_temizle_i` coincident with an increment: the clear wins and the result is 0.
- **Outputs**
  - `verici_veri_o` and `verici_baud_div_o` are registers.
  - `mesgul_o` is decoded from the state.

## Timing
- Reset value of every output: all outputs are 0, including the data, baud and sent-counter registers. The state is BOSTA.
- Reset asserted mid-frame: immediate return to BOSTA; the in-flight byte is abandoned.
- Pop to start: pop in cycle N, `verici_basla_o` in N+1.
- Minimum turnaround with `ara_bosluk_i`=0:
  - `verici_hazir_i` is seen high in cycle M.
  - BOSTA is in M+1, where the next pop can occur.
  - The next start is in M+2.
- With gap G: ARA occupies M+1..M+G, BOSTA is M+G+1, and the next start is M+G+2.
- Never more than one pop per frame; `fifo_oku_o` is never high while `fifo_bos_i`=1.
- FIFO becomes empty during a gap: the block stays in BOSTA with no pop until it is non-empty.
- Idle state: if `verici_hazir_i` stays low, the block waits indefinitely. There is no timeout.

## Test plan
- **Single byte**
  - Stimulus: FIFO holds 0xA5, `baud_div_i`=16, gap 0, `tx_en_i`=1.
  - Required response: one `fifo_oku_o` pulse; `verici_basla_o` one cycle later with `verici_veri_o`=0xA5 and `verici_baud_div_o`=16. The counter reads 1 after `verici_hazir_i` rises, and `mesgul_o` then falls.
- **Burst with gap**
  - Stimulus: FIFO holds 0x01,0x02,0x03; `ara_bosluk_i`=5.
  - Required response: three frames in order. Exactly 5 ARA cycles between each hazir rise and the next pop. Counter ends at 3.
- **Blocking conditions**
  - Stimulus: (a) `baud_div_i`=0 with a non-empty FIFO; (b) `tx_en_i`=0 with a non-empty FIFO.
  - Required response: neither case pops or starts over 1000 cycles.
- **Enable and baud changes mid-frame**
  - Stimulus: drop `tx_en_i` and change `baud_div_i` to 99 during BITIS_BEKLE.
  - Required response: the frame completes with divisor 16, and no further pop occurs.
- **Counter clear and wrap**
  - Stimulus: `sayac_temizle_i` coincident with the hazir rise; then a counter preloaded to 0xFFFF followed by one frame.
  - Required response: the counter is 0 in both cases.
- **Reset mid-frame**
  - Stimulus: assert `rstn_i`=0 in DUSUS_BEKLE.
  - Required response: all outputs go to 0 asynchronously and the block is in BOSTA. After release it restarts cleanly with the next FIFO byte.
